// File: rtl/nms_monitor_pkg.sv
// Shared definitions for the NMS deadlock-monitoring path: FSM state
// encoding, default thresholds and the index-width helper.
package nms_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WATCH    = 2'd1,
    ST_DEADLOCK = 2'd2
  } nms_state_e;

  localparam int DEF_NUM_CH       = 2;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_STALL_THRESH = 1024;
  localparam int DEF_CONFIRM_CYC  = 256;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nms_stall_counter.sv
// Per-channel stall run-length counter; flags a channel as blocked once it
// has been stalled for STALL_THRESH consecutive samples.
module nms_stall_counter
  import nms_monitor_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STALL_THRESH = DEF_STALL_THRESH
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic stall,
  output logic blocked
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at the threshold so the flag stays up for as long as the stall lasts.
  always_comb begin
    cnt_d = '0;
    if (stall) begin
      cnt_d = (cnt_q == THRESH) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign blocked = (cnt_q == THRESH);

endmodule

// File: rtl/nms_axis_stall_detector.sv
// Taps NMS AXI-Stream handshakes, raises per-channel block flags and confirms
// a persistent block as a sticky deadlock with first-offender and event count.
module nms_axis_stall_detector
  import nms_monitor_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STALL_THRESH = DEF_STALL_THRESH,
  parameter int CONFIRM_CYC  = DEF_CONFIRM_CYC,
  localparam int IDX_W       = idx_w(NUM_CH)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              clear,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              any_block,
  output logic              deadlock,
  output logic [IDX_W-1:0]  first_ch,
  output logic [CNT_W-1:0]  event_count
);

  localparam int                CONF_W    = $clog2(CONFIRM_CYC) + 1;
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_CYC - 1);

  logic [NUM_CH-1:0] stall;
  logic [IDX_W-1:0]  lowest_blocked;

  nms_state_e        state_q, state_d;
  logic [CONF_W-1:0] conf_cnt_q, conf_cnt_d;
  logic [IDX_W-1:0]  first_ch_q, first_ch_d;
  logic [CNT_W-1:0]  event_count_q, event_count_d;

  assign stall = ch_mask & ch_tvalid & ~ch_tready;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      nms_stall_counter #(
        .CNT_W        (CNT_W),
        .STALL_THRESH (STALL_THRESH)
      ) u_stall_counter (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .stall    (stall[gi]),
        .blocked  (axis_block_sigs[gi])
      );
    end
  endgenerate

  assign any_block = |axis_block_sigs;

  // Scan downwards so the lowest blocked index wins.
  always_comb begin
    lowest_blocked = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (axis_block_sigs[i]) begin
        lowest_blocked = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    conf_cnt_d    = conf_cnt_q;
    first_ch_d    = first_ch_q;
    event_count_d = event_count_q;
    if (clear) begin
      state_d       = ST_IDLE;
      conf_cnt_d    = '0;
      first_ch_d    = '0;
      event_count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_block) begin
            state_d    = ST_WATCH;
            conf_cnt_d = '0;
            first_ch_d = lowest_blocked;
            if (event_count_q != {CNT_W{1'b1}}) begin
              event_count_d = event_count_q + CNT_W'(1);
            end
          end
        end
        ST_WATCH: begin
          if (!any_block) begin
            state_d = ST_IDLE;
          end else if (conf_cnt_q == CONF_LAST) begin
            state_d = ST_DEADLOCK;
          end else begin
            conf_cnt_d = conf_cnt_q + CONF_W'(1);
          end
        end
        ST_DEADLOCK: begin
          state_d = ST_DEADLOCK;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q       <= ST_IDLE;
      conf_cnt_q    <= '0;
      first_ch_q    <= '0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      conf_cnt_q    <= conf_cnt_d;
      first_ch_q    <= first_ch_d;
      event_count_q <= event_count_d;
    end
  end

  assign deadlock    = (state_q == ST_DEADLOCK);
  assign first_ch    = first_ch_q;
  assign event_count = event_count_q;

endmodule

// File: tb/tb_nms_axis_stall_detector.sv
// Directed bench for nms_axis_stall_detector with a run-length based
// reference model checked every cycle, plus hand-computed spot checks.
module tb_nms_axis_stall_detector;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int THR    = 4;
  localparam int CONF   = 3;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic [NUM_CH-1:0] ch_tvalid = '0;
  logic [NUM_CH-1:0] ch_tready = '0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic              clear = 1'b0;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              any_block;
  logic              deadlock;
  logic [0:0]        first_ch;
  logic [CNT_W-1:0]  event_count;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  nms_axis_stall_detector #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .STALL_THRESH (THR),
    .CONFIRM_CYC  (CONF)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .ch_tvalid       (ch_tvalid),
    .ch_tready       (ch_tready),
    .ch_mask         (ch_mask),
    .clear           (clear),
    .axis_block_sigs (axis_block_sigs),
    .any_block       (any_block),
    .deadlock        (deadlock),
    .first_ch        (first_ch),
    .event_count     (event_count)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: run[i] = length of the current unbroken stall run.
  // A channel is blocked once its run reaches THR. m_mode: 0 idle, 1 watching,
  // 2 deadlocked; m_age counts edges spent in watch with the block present.
  int run [NUM_CH];
  int m_mode = 0;
  int m_age = 0;
  int m_first = 0;
  int m_ev = 0;

  initial begin
    for (int i = 0; i < NUM_CH; i++) run[i] = 0;
  end

  always @(posedge ap_clk) begin
    bit any_b;
    int fidx;
    any_b = 1'b0;
    fidx  = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (run[i] >= THR) begin
        any_b = 1'b1;
        fidx  = i;
      end
    end
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) run[i] = 0;
      m_mode = 0; m_age = 0; m_first = 0; m_ev = 0;
    end else begin
      if (clear) begin
        m_mode = 0; m_age = 0; m_first = 0; m_ev = 0;
      end else if (m_mode == 0) begin
        if (any_b) begin
          m_mode  = 1;
          m_age   = 1;
          m_first = fidx;
          m_ev    = (m_ev < 255) ? m_ev + 1 : 255;
        end
      end else if (m_mode == 1) begin
        if (!any_b) m_mode = 0;
        else if (m_age == CONF) m_mode = 2;
        else m_age++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_mask[i] && ch_tvalid[i] && !ch_tready[i])
          run[i] = (run[i] < 1000) ? run[i] + 1 : run[i];
        else
          run[i] = 0;
      end
    end
  end

  always @(negedge ap_clk) begin
    if (check_en) begin
      int exp_blk;
      exp_blk = 0;
      for (int i = 0; i < NUM_CH; i++) if (run[i] >= THR) exp_blk |= (1 << i);
      chk("model_block_sigs", int'(axis_block_sigs), exp_blk);
      chk("model_any_block", int'(any_block), int'(exp_blk != 0));
      chk("model_deadlock", int'(deadlock), int'(m_mode == 2));
      chk("model_first_ch", int'(first_ch), m_first);
      chk("model_event_count", int'(event_count), m_ev);
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] r, input logic [1:0] m);
    ch_tvalid = v;
    ch_tready = r;
    ch_mask   = m;
  endtask

  // Two reset edges with ch0 stalled; next edge after return is edge 1.
  task automatic do_reset();
    ap_rst_n = 1'b0;
    clear    = 1'b0;
    drive(2'b01, 2'b00, 2'b11);
    tick();
    check_en = 1'b1;
    tick();
    chk("reset_block_sigs", int'(axis_block_sigs), 0);
    chk("reset_any_block", int'(any_block), 0);
    chk("reset_deadlock", int'(deadlock), 0);
    chk("reset_first_ch", int'(first_ch), 0);
    chk("reset_event_count", int'(event_count), 0);
    ap_rst_n = 1'b1;
    drive(2'b00, 2'b00, 2'b11);
  endtask

  initial begin
    // Continuous stall on ch0
    do_reset();
    drive(2'b01, 2'b00, 2'b11);
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) chk("cont_blk_e3", int'(axis_block_sigs), 0);
      if (e == 4) chk("cont_blk_e4", int'(axis_block_sigs), 1);
      if (e == 4) chk("cont_ev_e4", int'(event_count), 0);
      if (e == 5) chk("cont_ev_e5", int'(event_count), 1);
      if (e == 5) chk("cont_first_e5", int'(first_ch), 0);
      if (e == 7) chk("cont_dead_e7", int'(deadlock), 0);
      if (e == 8) chk("cont_dead_e8", int'(deadlock), 1);
      if (e == 10) chk("cont_dead_e10", int'(deadlock), 1);
    end

    // Transient stall on ch1, transfer at edge 6
    do_reset();
    drive(2'b10, 2'b00, 2'b11);
    for (int e = 1; e <= 12; e++) begin
      if (e == 6) drive(2'b10, 2'b10, 2'b11);
      tick();
      if (e == 4) chk("trans_blk_e4", int'(axis_block_sigs), 2);
      if (e == 5) chk("trans_first_e5", int'(first_ch), 1);
      if (e == 6) chk("trans_blk_e6", int'(axis_block_sigs), 0);
      if (e == 12) chk("trans_dead_e12", int'(deadlock), 0);
      if (e == 12) chk("trans_ev_e12", int'(event_count), 1);
    end

    // Simultaneous blocks, both enabled then ch0 masked
    do_reset();
    drive(2'b11, 2'b00, 2'b11);
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 4) chk("simul_blk_e4", int'(axis_block_sigs), 3);
      if (e == 5) chk("simul_first_e5", int'(first_ch), 0);
    end
    do_reset();
    drive(2'b11, 2'b00, 2'b10);
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 4) chk("masked_blk_e4", int'(axis_block_sigs), 2);
      if (e == 5) chk("masked_first_e5", int'(first_ch), 1);
    end

    // Clear while deadlocked with the stall still held
    do_reset();
    drive(2'b01, 2'b00, 2'b11);
    for (int e = 1; e <= 16; e++) begin
      clear = (e == 10);
      tick();
      if (e == 9) chk("clr_dead_e9", int'(deadlock), 1);
      if (e == 10) chk("clr_dead_e10", int'(deadlock), 0);
      if (e == 10) chk("clr_ev_e10", int'(event_count), 0);
      if (e == 11) chk("clr_ev_e11", int'(event_count), 1);
      if (e == 13) chk("clr_dead_e13", int'(deadlock), 0);
      if (e == 14) chk("clr_dead_e14", int'(deadlock), 1);
    end
    clear = 1'b0;

    // Saturation: 300 short episodes of 5 stalls then one transfer
    do_reset();
    for (int ep = 1; ep <= 300; ep++) begin
      drive(2'b01, 2'b00, 2'b11);
      repeat (5) tick();
      drive(2'b01, 2'b01, 2'b11);
      tick();
      if (ep == 10) chk("sat_ev_10", int'(event_count), 10);
      if (ep == 255) chk("sat_ev_255", int'(event_count), 255);
    end
    drive(2'b00, 2'b00, 2'b11);
    repeat (3) tick();
    chk("sat_ev_final", int'(event_count), 255);
    chk("sat_dead_final", int'(deadlock), 0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
